// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_pkg;

    localparam int IMEM_ADDR_BITS = 12;

    // Requester identity; also the encoding held in the round-robin pointer.
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_e;

    // Access granted last cycle whose response is delivered this cycle.
    typedef struct packed {
        logic  valid;
        port_e port;
        logic  err;
        logic  we;
    } pend_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and BRAM signals around the arbiter.
interface imem_port_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_BITS = IMEM_ADDR_BITS
);
    // Fetch port
    logic                 if_req;
    logic [31:0]          if_addr;
    logic                 if_gnt;
    logic                 if_flush;
    logic                 if_rvalid;
    logic [31:0]          if_rdata;
    logic                 if_err;
    // Loader / debug port
    logic                 ld_req;
    logic                 ld_we;
    logic [31:0]          ld_addr;
    logic [31:0]          ld_wdata;
    logic                 ld_gnt;
    logic                 ld_rvalid;
    logic                 ld_err;
    logic [31:0]          ld_rdata;
    // BRAM side
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    // Environment side: requesters and the BRAM itself.
    modport master (
        output if_req, if_addr, if_flush,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_flush,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on contention the port not granted last wins.
module rr_arb2
    import imem_pkg::*;
#(
    parameter bit RESET_LAST_LOADER = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_ld,
    output logic gnt_if,
    output logic gnt_ld
);

    port_e last_gnt;

    // Combinational grant: a lone requester always wins, contention alternates.
    always_comb begin
        gnt_if = req_if && (!req_ld || (last_gnt == PORT_LD));
        gnt_ld = req_ld && (!req_if || (last_gnt == PORT_IF));
    end

    // Pointer moves only when something is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= RESET_LAST_LOADER ? PORT_LD : PORT_IF;
        end else if (gnt_if) begin
            last_gnt <= PORT_IF;
        end else if (gnt_ld) begin
            last_gnt <= PORT_LD;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous instruction BRAM between fetch (read-only) and loader (read/write).
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_BITS         = IMEM_ADDR_BITS,
    parameter bit RESET_LAST_LOADER = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
);

    logic        gnt_if;
    logic        gnt_ld;
    logic [31:0] sel_addr;
    logic        in_range;
    logic        unused_addr_lsbs;
    logic [31:0] resp_data;
    pend_t       pend_d;
    pend_t       pend_q;

    rr_arb2 #(
        .RESET_LAST_LOADER (RESET_LAST_LOADER)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_if (bus.if_req),
        .req_ld (bus.ld_req),
        .gnt_if (gnt_if),
        .gnt_ld (gnt_ld)
    );

    // Winner selection, range check and BRAM drive.
    always_comb begin
        sel_addr         = gnt_ld ? bus.ld_addr : bus.if_addr;
        in_range         = (sel_addr[31:ADDR_BITS+2] == '0);
        unused_addr_lsbs = ^sel_addr[1:0];
        bus.if_gnt       = gnt_if;
        bus.ld_gnt       = gnt_ld;
        bus.mem_en       = (gnt_if || gnt_ld) && in_range;
        bus.mem_we       = gnt_ld && in_range && bus.ld_we;
        bus.mem_addr     = sel_addr[ADDR_BITS+1:2];
        bus.mem_wdata    = bus.ld_wdata;
    end

    // Next pending response; a fetch flushed at grant time is never queued.
    always_comb begin
        pend_d = '0;
        if (gnt_if || gnt_ld) begin
            pend_d.valid = !(gnt_if && bus.if_flush);
            pend_d.port  = gnt_ld ? PORT_LD : PORT_IF;
            pend_d.err   = !in_range;
            pend_d.we    = gnt_ld && bus.ld_we;
        end
    end

    // Pending-response register; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Route the response to its port; writes and errors return zero data.
    always_comb begin
        resp_data     = (pend_q.err || pend_q.we) ? '0 : bus.mem_rdata;
        bus.if_rvalid = pend_q.valid && (pend_q.port == PORT_IF) && !bus.if_flush;
        bus.ld_rvalid = pend_q.valid && (pend_q.port == PORT_LD);
        bus.if_err    = bus.if_rvalid && pend_q.err;
        bus.ld_err    = bus.ld_rvalid && pend_q.err;
        bus.if_rdata  = bus.if_rvalid ? resp_data : '0;
        bus.ld_rdata  = bus.ld_rvalid ? resp_data : '0;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with a transaction-level reference model.
module tb_imem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_BITS(12)) bus ();

    imem_port_arbiter #(
        .ADDR_BITS         (12),
        .RESET_LAST_LOADER (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural BRAM: read-first, data valid the cycle after enable.
    logic [31:0] bram [0:4095] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= bram[bus.mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: who was granted last, the one outstanding response, memory image.
    bit          m_last_ld = 1'b1;
    bit          m_pv, m_pld, m_perr, m_pwe;
    logic [31:0] m_pdata;
    logic [31:0] ref_mem [0:4095] = '{default: '0};

    bit          w_if, w_ld, m_inr;
    int unsigned m_word;
    logic [31:0] m_addr;
    bit          e_mem_en, e_mem_we;
    bit          e_if_rvalid, e_if_err, e_ld_rvalid, e_ld_err;
    logic [31:0] e_rdata, e_if_rdata, e_ld_rdata;

    task automatic model_eval();
        if (bus.if_req && bus.ld_req) begin
            w_if = m_last_ld;
            w_ld = !m_last_ld;
        end else begin
            w_if = bus.if_req;
            w_ld = bus.ld_req;
        end
        m_addr      = w_ld ? bus.ld_addr : bus.if_addr;
        m_inr       = (m_addr / 32'd16384) == 0;
        m_word      = (m_addr % 16384) / 4;
        e_mem_en    = (w_if || w_ld) && m_inr;
        e_mem_we    = w_ld && m_inr && bus.ld_we;
        e_if_rvalid = m_pv && !m_pld && !bus.if_flush;
        e_ld_rvalid = m_pv && m_pld;
        e_if_err    = e_if_rvalid && m_perr;
        e_ld_err    = e_ld_rvalid && m_perr;
        e_rdata     = (m_perr || m_pwe) ? 32'd0 : m_pdata;
        e_if_rdata  = e_if_rvalid ? e_rdata : 32'd0;
        e_ld_rdata  = e_ld_rvalid ? e_rdata : 32'd0;
    endtask

    task automatic model_commit();
        if (rst) begin
            m_last_ld = 1'b1;
            m_pv      = 1'b0;
        end else if (w_if || w_ld) begin
            m_last_ld = w_ld;
            m_pv      = !(w_if && bus.if_flush);
            m_pld     = w_ld;
            m_perr    = !m_inr;
            m_pwe     = w_ld && bus.ld_we;
            m_pdata   = m_inr ? ref_mem[m_word] : 32'd0;
            if (e_mem_we) ref_mem[m_word] = bus.ld_wdata;
        end else begin
            m_pv = 1'b0;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'd0;
        bus.if_flush = 1'b0;
        bus.ld_req   = 1'b0;
        bus.ld_we    = 1'b0;
        bus.ld_addr  = 32'd0;
        bus.ld_wdata = 32'd0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(4, 0) == 0) return $urandom | 32'h0010_0000;
        return ($urandom_range(63, 0) * 4) + $urandom_range(3, 0);
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        #2;
        model_eval();
        n_checks++; if (bus.if_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_if_rvalid: got %b expected 0", bus.if_rvalid); end
        n_checks++; if (bus.ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_ld_rvalid: got %b expected 0", bus.ld_rvalid); end
        n_checks++; if (bus.if_err !== 1'b0 || bus.ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b expected 0/0", bus.if_err, bus.ld_err); end
        n_checks++; if (bus.if_rdata !== 32'd0 || bus.ld_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.ld_rdata); end
        n_checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got en=%b we=%b expected 0/0", bus.mem_en, bus.mem_we); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch_seq();
        logic [31:0] pre [3];
        pre[0] = 32'h11; pre[1] = 32'h22; pre[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.ld_req = 1'b1; bus.ld_we = 1'b1;
            bus.ld_addr = 32'(i * 4); bus.ld_wdata = pre[i];
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i < 3) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'(i * 4);
            end
            #2;
            model_eval();
            n_checks++; if (bus.if_gnt !== w_if) begin n_fail++; $display("FAIL fetch_seq_gnt[%0d]: got %b expected %b", i, bus.if_gnt, w_if); end
            n_checks++; if (bus.if_rvalid !== e_if_rvalid || bus.if_rdata !== e_if_rdata) begin
                n_fail++; $display("FAIL fetch_seq_resp[%0d]: got v=%b d=%h expected v=%b d=%h", i, bus.if_rvalid, bus.if_rdata, e_if_rvalid, e_if_rdata);
            end
            tick();
        end
    endtask

    task automatic test_write_then_fetch();
        idle();
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h10; bus.ld_wdata = 32'hDEAD_BEEF;
        #2;
        model_eval();
        n_checks++; if (bus.mem_we !== e_mem_we || bus.mem_addr !== 12'(m_word)) begin
            n_fail++; $display("FAIL wr_mem: got we=%b addr=%h expected we=%b addr=%h", bus.mem_we, bus.mem_addr, e_mem_we, 12'(m_word));
        end
        tick();
        idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        #2;
        model_eval();
        n_checks++; if (bus.mem_we !== e_mem_we) begin n_fail++; $display("FAIL wr_once: got we=%b expected %b", bus.mem_we, e_mem_we); end
        n_checks++; if (bus.ld_rvalid !== e_ld_rvalid || bus.ld_rdata !== e_ld_rdata) begin
            n_fail++; $display("FAIL wr_resp: got v=%b d=%h expected v=%b d=%h", bus.ld_rvalid, bus.ld_rdata, e_ld_rvalid, e_ld_rdata);
        end
        tick();
        idle();
        #2;
        model_eval();
        n_checks++; if (bus.if_rvalid !== e_if_rvalid || bus.if_rdata !== e_if_rdata) begin
            n_fail++; $display("FAIL rd_after_wr: got v=%b d=%h expected v=%b d=%h", bus.if_rvalid, bus.if_rdata, e_if_rvalid, e_if_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        test_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin
                bus.if_req = 1'b1; bus.if_addr = 32'h0;
                bus.ld_req = 1'b1; bus.ld_addr = 32'h8;
            end
            #2;
            model_eval();
            n_checks++; if (bus.if_gnt !== w_if || bus.ld_gnt !== w_ld) begin
                n_fail++; $display("FAIL contention_gnt[%0d]: got if=%b ld=%b expected if=%b ld=%b", i, bus.if_gnt, bus.ld_gnt, w_if, w_ld);
            end
            n_checks++; if (bus.if_rvalid !== e_if_rvalid || bus.ld_rvalid !== e_ld_rvalid || bus.if_rdata !== e_if_rdata || bus.ld_rdata !== e_ld_rdata) begin
                n_fail++; $display("FAIL contention_resp[%0d]: got if=%b/%h ld=%b/%h expected if=%b/%h ld=%b/%h", i,
                    bus.if_rvalid, bus.if_rdata, bus.ld_rvalid, bus.ld_rdata, e_if_rvalid, e_if_rdata, e_ld_rvalid, e_ld_rdata);
            end
            tick();
        end
    endtask

    task automatic test_out_of_range();
        idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h0001_0000;
        #2;
        model_eval();
        n_checks++; if (bus.if_gnt !== w_if || bus.mem_en !== e_mem_en) begin
            n_fail++; $display("FAIL oor_grant: got gnt=%b en=%b expected gnt=%b en=%b", bus.if_gnt, bus.mem_en, w_if, e_mem_en);
        end
        tick();
        idle();
        #2;
        model_eval();
        n_checks++; if (bus.if_rvalid !== e_if_rvalid || bus.if_err !== e_if_err || bus.if_rdata !== e_if_rdata) begin
            n_fail++; $display("FAIL oor_resp: got v=%b e=%b d=%h expected v=%b e=%b d=%h", bus.if_rvalid, bus.if_err, bus.if_rdata, e_if_rvalid, e_if_err, e_if_rdata);
        end
        tick();
    endtask

    task automatic test_flush();
        // Flush on the delivery cycle while a loader read is granted.
        idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        tick();
        idle();
        bus.if_flush = 1'b1; bus.ld_req = 1'b1; bus.ld_addr = 32'h8;
        #2;
        model_eval();
        n_checks++; if (bus.if_rvalid !== e_if_rvalid) begin n_fail++; $display("FAIL flush_delivery: got %b expected %b", bus.if_rvalid, e_if_rvalid); end
        n_checks++; if (bus.ld_gnt !== w_ld) begin n_fail++; $display("FAIL flush_ld_gnt: got %b expected %b", bus.ld_gnt, w_ld); end
        tick();
        idle();
        #2;
        model_eval();
        n_checks++; if (bus.ld_rvalid !== e_ld_rvalid || bus.ld_rdata !== e_ld_rdata) begin
            n_fail++; $display("FAIL flush_ld_resp: got v=%b d=%h expected v=%b d=%h", bus.ld_rvalid, bus.ld_rdata, e_ld_rvalid, e_ld_rdata);
        end
        tick();
        // Flush on the grant cycle: still granted, response suppressed.
        idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h0; bus.if_flush = 1'b1;
        #2;
        model_eval();
        n_checks++; if (bus.if_gnt !== w_if) begin n_fail++; $display("FAIL flush_grant_gnt: got %b expected %b", bus.if_gnt, w_if); end
        tick();
        idle();
        #2;
        model_eval();
        n_checks++; if (bus.if_rvalid !== e_if_rvalid) begin n_fail++; $display("FAIL flush_grant_resp: got %b expected %b", bus.if_rvalid, e_if_rvalid); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        tick();
        idle();
        bus.ld_req = 1'b1; bus.ld_addr = 32'h8;
        #2;
        model_eval();
        n_checks++; if (bus.ld_gnt !== w_ld) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected %b", bus.ld_gnt, w_ld); end
        #1;
        rst = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #2;
            model_eval();
            n_checks++; if (bus.ld_rvalid !== e_ld_rvalid) begin n_fail++; $display("FAIL rstmid_rvalid[%0d]: got %b expected %b", i, bus.ld_rvalid, e_ld_rvalid); end
            tick();
        end
        rst = 1'b0;
        bus.if_req = 1'b1; bus.ld_req = 1'b1; bus.ld_addr = 32'h8;
        #2;
        model_eval();
        n_checks++; if (bus.if_gnt !== w_if || bus.ld_gnt !== w_ld) begin
            n_fail++; $display("FAIL rstmid_ptr: got if=%b ld=%b expected if=%b ld=%b", bus.if_gnt, bus.ld_gnt, w_if, w_ld);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        bit hold_if = 1'b0;
        bit hold_ld = 1'b0;
        idle();
        for (int i = 0; i < 400; i++) begin
            if (!hold_if) begin
                bus.if_req  = $urandom_range(1, 0) == 1;
                bus.if_addr = rand_addr();
            end
            if (!hold_ld) begin
                bus.ld_req   = $urandom_range(1, 0) == 1;
                bus.ld_we    = $urandom_range(1, 0) == 1;
                bus.ld_addr  = rand_addr();
                bus.ld_wdata = $urandom;
            end
            bus.if_flush = $urandom_range(5, 0) == 0;
            #2;
            model_eval();
            n_checks++; if (bus.if_gnt !== w_if || bus.ld_gnt !== w_ld) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got if=%b ld=%b expected if=%b ld=%b", i, bus.if_gnt, bus.ld_gnt, w_if, w_ld);
            end
            n_checks++; if (bus.mem_en !== e_mem_en || bus.mem_we !== e_mem_we) begin
                n_fail++; $display("FAIL rnd_mem_ctl[%0d]: got en=%b we=%b expected en=%b we=%b", i, bus.mem_en, bus.mem_we, e_mem_en, e_mem_we);
            end
            if (e_mem_en) begin
                n_checks++; if (bus.mem_addr !== 12'(m_word)) begin n_fail++; $display("FAIL rnd_mem_addr[%0d]: got %h expected %h", i, bus.mem_addr, 12'(m_word)); end
            end
            if (e_mem_we) begin
                n_checks++; if (bus.mem_wdata !== bus.ld_wdata) begin n_fail++; $display("FAIL rnd_mem_wdata[%0d]: got %h expected %h", i, bus.mem_wdata, bus.ld_wdata); end
            end
            n_checks++; if (bus.if_rvalid !== e_if_rvalid || bus.if_err !== e_if_err || bus.if_rdata !== e_if_rdata) begin
                n_fail++; $display("FAIL rnd_if_resp[%0d]: got v=%b e=%b d=%h expected v=%b e=%b d=%h", i, bus.if_rvalid, bus.if_err, bus.if_rdata, e_if_rvalid, e_if_err, e_if_rdata);
            end
            n_checks++; if (bus.ld_rvalid !== e_ld_rvalid || bus.ld_err !== e_ld_err || bus.ld_rdata !== e_ld_rdata) begin
                n_fail++; $display("FAIL rnd_ld_resp[%0d]: got v=%b e=%b d=%h expected v=%b e=%b d=%h", i, bus.ld_rvalid, bus.ld_err, bus.ld_rdata, e_ld_rvalid, e_ld_err, e_ld_rdata);
            end
            hold_if = bus.if_req && !w_if;
            hold_ld = bus.ld_req && !w_ld;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch_seq();
        test_write_then_fetch();
        test_contention();
        test_out_of_range();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
